// File: rtl/uart_pkg.sv
// Shared definitions for the UART framed-receive path: parser state encoding
// and default frame constants.
package uart_pkg;

  localparam int         DEF_ADDR_W    = 14;
  localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    HUNT,
    LEN_HI,
    LEN_LO,
    PAYLOAD,
    CSUM,
    DONE,
    ERR
  } rx_state_e;

endpackage

// File: rtl/rx_packet_parser_edge_detect.sv
// Registers the UART byte-valid level and emits a one-cycle pulse on its
// registered 0->1 transition, so a level held high is accepted only once.
module rx_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic level_i,
  output logic rise_o
);

  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= level_i;
      prev_q <= sync_q;
    end
  end

  assign rise_o = sync_q & ~prev_q;

endmodule

// File: rtl/rx_packet_parser.sv
// Sync-hunting frame parser: sync, 14-bit length, payload to MEM, 8-bit checksum.
// Optional inter-byte idle timeout enabled by defining RX_PARSER_TIMEOUT_EN.
module rx_packet_parser
  import uart_pkg::*;
#(
  parameter int          NUM_DATA       = 10000,
  parameter int          ADDR_W         = DEF_ADDR_W,
  parameter logic [7:0]  SYNC_BYTE      = DEF_SYNC_BYTE,
  parameter int unsigned TIMEOUT_CYCLES = 96000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        data_input,
  input  logic              data_ready,
  output logic              MEM_write_enable,
  output logic [ADDR_W-1:0] MEM_write_addr,
  output logic [7:0]        MEM_write_data,
  output logic              finish,
  output logic              pkt_error,
  output logic [ADDR_W-1:0] pkt_len,
  output logic              busy
);

  rx_state_e         state_q, state_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [ADDR_W-1:0] pkt_len_q, pkt_len_d;
  logic [7:0]        sum_q, sum_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              finish_q, finish_d;
  logic              err_q, err_d;

  logic              accept;
  logic              timeout_w;
  logic [ADDR_W-1:0] len_full;
  logic [ADDR_W-1:0] idx_inc;
  logic [7:0]        sum_add;

  rx_edge_detect u_edge (
    .clk     (clk),
    .rst     (rst),
    .level_i (data_ready),
    .rise_o  (accept)
  );

  assign busy     = (state_q != HUNT) && (state_q != DONE);
  // LEN_HI leaves the low byte of len_q zero, so OR-ing completes the length.
  assign len_full = len_q | ADDR_W'(data_input);
  assign idx_inc  = idx_q + ADDR_W'(1);
  assign sum_add  = sum_q + data_input;

`ifdef RX_PARSER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] tmo_q, tmo_d;

  always_comb begin
    tmo_d = tmo_q + CNT_W'(1);
    if (accept || !busy) tmo_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst) tmo_q <= '0;
    else      tmo_q <= tmo_d;
  end

  assign timeout_w = busy && (state_q != ERR) && (tmo_q == CNT_W'(TIMEOUT_CYCLES));
`else
  logic unused_tmo;
  assign unused_tmo = ^TIMEOUT_CYCLES;
  assign timeout_w  = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    idx_d     = idx_q;
    sum_d     = sum_q;
    we_d      = 1'b0;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    finish_d  = finish_q;
    err_d     = err_q;
    pkt_len_d = pkt_len_q;

    unique case (state_q)
      HUNT: if (accept && data_input == SYNC_BYTE) begin
        state_d = LEN_HI;
        sum_d   = 8'h00;
        err_d   = 1'b0;
      end
      LEN_HI: if (accept) begin
        if (data_input[7:6] != 2'b00) begin
          state_d = ERR;
        end else begin
          len_d   = ADDR_W'({data_input[5:0], 8'h00});
          sum_d   = sum_add;
          state_d = LEN_LO;
        end
      end
      LEN_LO: if (accept) begin
        len_d = len_full;
        sum_d = sum_add;
        if (len_full == '0 || len_full > ADDR_W'(NUM_DATA)) begin
          state_d = ERR;
        end else begin
          idx_d   = '0;
          state_d = PAYLOAD;
        end
      end
      PAYLOAD: if (accept) begin
        we_d    = 1'b1;
        waddr_d = idx_q;
        wdata_d = data_input;
        sum_d   = sum_add;
        idx_d   = idx_inc;
        if (idx_inc == len_q) state_d = CSUM;
      end
      CSUM: if (accept) begin
        if (sum_add == 8'h00) begin
          state_d   = DONE;
          finish_d  = 1'b1;
          pkt_len_d = len_q;
        end else begin
          state_d = ERR;
        end
      end
      DONE: ;
      ERR: begin
        err_d   = 1'b1;
        state_d = HUNT;
      end
      default: state_d = HUNT;
    endcase

    if (timeout_w) state_d = ERR;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= HUNT;
      len_q     <= '0;
      idx_q     <= '0;
      sum_q     <= 8'h00;
      we_q      <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= 8'h00;
      finish_q  <= 1'b0;
      err_q     <= 1'b0;
      pkt_len_q <= '0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      sum_q     <= sum_d;
      we_q      <= we_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      finish_q  <= finish_d;
      err_q     <= err_d;
      pkt_len_q <= pkt_len_d;
    end
  end

  assign MEM_write_enable = we_q;
  assign MEM_write_addr   = waddr_q;
  assign MEM_write_data   = wdata_q;
  assign finish           = finish_q;
  assign pkt_error        = err_q;
  assign pkt_len          = pkt_len_q;

endmodule

// File: tb/tb_rx_packet_parser.sv
// Directed bench for rx_packet_parser: good/bad frames, length limits,
// level handling, mid-frame reset and (when enabled) the idle timeout.
module tb_rx_packet_parser;

  localparam int TMO = 3000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  data_input = 8'h00;
  logic        data_ready = 1'b0;
  logic        we;
  logic [13:0] waddr;
  logic [7:0]  wdata;
  logic        finish;
  logic        pkt_error;
  logic [13:0] pkt_len;
  logic        busy;

  int checks = 0;
  int errors = 0;

  int          wr_total = 0;
  logic [13:0] last_addr = '0;
  logic [7:0]  last_data = '0;
  logic [7:0]  mem [0:16383];

  always #5 clk = ~clk;

  rx_packet_parser #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk              (clk),
    .rst              (rst),
    .data_input       (data_input),
    .data_ready       (data_ready),
    .MEM_write_enable (we),
    .MEM_write_addr   (waddr),
    .MEM_write_data   (wdata),
    .finish           (finish),
    .pkt_error        (pkt_error),
    .pkt_len          (pkt_len),
    .busy             (busy)
  );

  always @(negedge clk) begin
    if (we === 1'b1) begin
      mem[waddr] <= wdata;
      wr_total   <= wr_total + 1;
      last_addr  <= waddr;
      last_data  <= wdata;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    data_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input int hold);
    @(negedge clk);
    data_input = b;
    data_ready = 1'b1;
    repeat (hold) @(negedge clk);
    data_ready = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_good(input int hold);
    send_byte(8'hA5, hold); send_byte(8'h00, hold); send_byte(8'h03, hold);
    send_byte(8'h11, hold); send_byte(8'h22, hold); send_byte(8'h33, hold);
    send_byte(8'h97, hold);
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({we, waddr, wdata, finish, pkt_error, pkt_len, busy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got we=%b addr=%0d data=%h fin=%b err=%b len=%0d busy=%b exp all 0",
               we, waddr, wdata, finish, pkt_error, pkt_len, busy);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_good_frame();
    int base;
    do_reset();
    base = wr_total;
    send_byte(8'hA5, 1);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL good_busy got %b exp 1", busy); end
    send_byte(8'h00, 1); send_byte(8'h03, 1);
    send_byte(8'h11, 1); send_byte(8'h22, 1); send_byte(8'h33, 1);
    send_byte(8'h97, 1);
    repeat (4) @(negedge clk);
    checks++;
    if (wr_total - base !== 3) begin errors++; $display("FAIL good_wr_cnt got %0d exp 3", wr_total - base); end
    checks++;
    if ({mem[0], mem[1], mem[2]} !== 24'h112233) begin
      errors++; $display("FAIL good_mem got %h %h %h exp 11 22 33", mem[0], mem[1], mem[2]);
    end
    checks++;
    if (finish !== 1'b1 || pkt_error !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL good_flags got fin=%b err=%b busy=%b exp 1 0 0", finish, pkt_error, busy);
    end
    checks++;
    if (pkt_len !== 14'd3) begin errors++; $display("FAIL good_len got %0d exp 3", pkt_len); end
    // DONE ignores further bytes
    base = wr_total;
    send_good(1);
    checks++;
    if (wr_total - base !== 0 || finish !== 1'b1) begin
      errors++; $display("FAIL done_sticky got writes=%0d fin=%b exp 0 1", wr_total - base, finish);
    end
  endtask

  task automatic test_bad_checksum();
    int base;
    do_reset();
    base = wr_total;
    send_byte(8'hA5, 1); send_byte(8'h00, 1); send_byte(8'h03, 1);
    send_byte(8'h11, 1); send_byte(8'h22, 1); send_byte(8'h33, 1);
    send_byte(8'h98, 1);
    repeat (4) @(negedge clk);
    checks++;
    if (wr_total - base !== 3) begin errors++; $display("FAIL badcs_wr_cnt got %0d exp 3", wr_total - base); end
    checks++;
    if (pkt_error !== 1'b1 || finish !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL badcs_flags got err=%b fin=%b busy=%b exp 1 0 0", pkt_error, finish, busy);
    end
    send_byte(8'hA5, 1);
    checks++;
    if (pkt_error !== 1'b0) begin errors++; $display("FAIL badcs_err_clear got %b exp 0", pkt_error); end
    send_byte(8'h00, 1); send_byte(8'h03, 1);
    send_byte(8'h11, 1); send_byte(8'h22, 1); send_byte(8'h33, 1);
    send_byte(8'h97, 1);
    repeat (4) @(negedge clk);
    checks++;
    if (finish !== 1'b1 || pkt_error !== 1'b0) begin
      errors++; $display("FAIL badcs_recover got fin=%b err=%b exp 1 0", finish, pkt_error);
    end
  endtask

  task automatic test_leading_junk();
    int base;
    do_reset();
    base = wr_total;
    send_byte(8'h00, 1); send_byte(8'hFF, 1); send_byte(8'h5A, 1);
    checks++;
    if (wr_total - base !== 0 || busy !== 1'b0) begin
      errors++; $display("FAIL junk_ignored got writes=%0d busy=%b exp 0 0", wr_total - base, busy);
    end
    send_good(1);
    checks++;
    if (wr_total - base !== 3 || last_addr !== 14'd2 || last_data !== 8'h33) begin
      errors++; $display("FAIL junk_writes got n=%0d addr=%0d data=%h exp 3 2 33", wr_total - base, last_addr, last_data);
    end
    checks++;
    if (finish !== 1'b1 || pkt_len !== 14'd3 || pkt_error !== 1'b0) begin
      errors++; $display("FAIL junk_flags got fin=%b len=%0d err=%b exp 1 3 0", finish, pkt_len, pkt_error);
    end
  endtask

  task automatic test_length_limits();
    logic [7:0] hi [3] = '{8'h27, 8'h40, 8'h00};
    logic [7:0] lo [3] = '{8'h11, 8'h00, 8'h00};
    int base;
    for (int k = 0; k < 3; k++) begin
      do_reset();
      base = wr_total;
      send_byte(8'hA5, 1); send_byte(hi[k], 1); send_byte(lo[k], 1);
      send_byte(8'h11, 1);
      repeat (4) @(negedge clk);
      checks++;
      if (pkt_error !== 1'b1 || finish !== 1'b0 || busy !== 1'b0 || wr_total - base !== 0) begin
        errors++;
        $display("FAIL len_limit_%0d got err=%b fin=%b busy=%b writes=%0d exp 1 0 0 0",
                 k, pkt_error, finish, busy, wr_total - base);
      end
    end
  endtask

  task automatic test_max_frame();
    int base;
    logic [7:0] s;
    logic [7:0] b;
    logic [7:0] lastb;
    do_reset();
    base = wr_total;
    s = 8'h27 + 8'h10;
    lastb = 8'h00;
    send_byte(8'hA5, 1); send_byte(8'h27, 1); send_byte(8'h10, 1);
    for (int i = 0; i < 10000; i++) begin
      b = 8'(i * 7 + 3);
      // mid-payload sync bytes must be stored as data
      if (i == 5) b = 8'hA5;
      s = s + b;
      lastb = b;
      send_byte(b, 1);
    end
    send_byte(8'h00 - s, 1);
    repeat (4) @(negedge clk);
    checks++;
    if (wr_total - base !== 10000 || last_addr !== 14'd9999 || last_data !== lastb) begin
      errors++; $display("FAIL max_writes got n=%0d addr=%0d data=%h exp 10000 9999 %h",
                         wr_total - base, last_addr, last_data, lastb);
    end
    checks++;
    if (mem[5] !== 8'hA5) begin errors++; $display("FAIL max_sync_as_data got %h exp a5", mem[5]); end
    checks++;
    if (finish !== 1'b1 || pkt_len !== 14'd10000 || pkt_error !== 1'b0) begin
      errors++; $display("FAIL max_flags got fin=%b len=%0d err=%b exp 1 10000 0", finish, pkt_len, pkt_error);
    end
  endtask

  task automatic test_level_hold();
    int base;
    do_reset();
    base = wr_total;
    send_good(1000);
    checks++;
    if (wr_total - base !== 3 || finish !== 1'b1 || pkt_len !== 14'd3) begin
      errors++; $display("FAIL hold_level got writes=%0d fin=%b len=%0d exp 3 1 3", wr_total - base, finish, pkt_len);
    end
  endtask

  task automatic test_reset_midframe();
    int base;
    do_reset();
    send_byte(8'hA5, 1); send_byte(8'h00, 1); send_byte(8'h03, 1);
    send_byte(8'h11, 1); send_byte(8'h22, 1);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({we, waddr, wdata, finish, pkt_error, pkt_len, busy} !== '0) begin
      errors++; $display("FAIL midreset_outputs got addr=%0d data=%h busy=%b exp 0 0 0", waddr, wdata, busy);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    base = wr_total;
    send_good(1);
    checks++;
    if (finish !== 1'b1 || wr_total - base !== 3) begin
      errors++; $display("FAIL midreset_recover got fin=%b writes=%0d exp 1 3", finish, wr_total - base);
    end
  endtask

`ifdef RX_PARSER_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    send_byte(8'hA5, 1); send_byte(8'h00, 1); send_byte(8'h03, 1);
    send_byte(8'h11, 1);
    repeat (TMO + 20) @(negedge clk);
    checks++;
    if (pkt_error !== 1'b1 || busy !== 1'b0 || finish !== 1'b0) begin
      errors++; $display("FAIL timeout_err got err=%b busy=%b fin=%b exp 1 0 0", pkt_error, busy, finish);
    end
    send_good(1);
    checks++;
    if (finish !== 1'b1 || pkt_error !== 1'b0) begin
      errors++; $display("FAIL timeout_recover got fin=%b err=%b exp 1 0", finish, pkt_error);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_good_frame();
    test_bad_checksum();
    test_leading_junk();
    test_length_limits();
    test_level_hold();
    test_reset_midframe();
`ifdef RX_PARSER_TIMEOUT_EN
    test_timeout();
`endif
    test_max_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rx_packet_parser.md
Name: rx_packet_parser

Overview:
- Framed-receive stage between the UART receiver (rx_data/rx_ready) and the input MEM write port.
- Hunts for a sync byte, reads a 14-bit length, and writes each payload byte to consecutive MEM addresses from 0.
- Verifies an 8-bit checksum, then raises finish, which starts the systolic Data_selector.
- Bad frames raise pkt_error and return to hunting.

Parameters:
- NUM_DATA, 10000: maximum payload length accepted.
- ADDR_W, 14: MEM address width.
- SYNC_BYTE, 8'hA5: frame start marker.
- TIMEOUT_CYCLES, 96000: inter-byte idle limit in clk cycles (10 ms at 9.6 MHz); used only with the optional feature.

Ports:
- clk  in  1: 9.6 MHz system clock.
- rst  in  1: synchronous, active-low reset.
- data_input  in  8: byte from the UART receiver.
- data_ready  in  1: receiver byte-valid level; may stay high many clk cycles.
- MEM_write_enable  out  1: one-cycle write strobe.
- MEM_write_addr  out  ADDR_W: payload byte index.
- MEM_write_data  out  8: payload byte.
- finish  out  1: good frame stored; sticky.
- pkt_error  out  1: last frame rejected; sticky until next sync.
- pkt_len  out  ADDR_W: length of the accepted frame.
- busy  out  1: high in any state other than HUNT or DONE.

Behaviour:
- Reset (rst=0 at a clk edge; wins over every other event): all outputs 0, state=HUNT, running sum=0, edge-detect register=0.
- Byte acceptance: a byte is accepted only on a 0->1 transition of registered data_ready. data_input is sampled on that edge cycle. Holding data_ready high never causes a second accept.
- FSM, one transition per accepted byte:
  - HUNT: byte==SYNC_BYTE -> LEN_HI, clear sum, clear pkt_error. Any other byte is ignored.
  - LEN_HI: if bits[7:6]!=0 -> ERR; else store len[13:8], sum+=byte -> LEN_LO.
  - LEN_LO: len[7:0]=byte, sum+=byte. If len==0 or len>NUM_DATA -> ERR; else reset write index to 0 -> PAYLOAD.
  - PAYLOAD: write the byte, sum+=byte, index++. Go to CSUM when index reaches len.
  - CSUM: if (sum+byte) mod 256 == 0 -> DONE, else -> ERR.
  - DONE: finish=1, pkt_len=len. All further bytes are ignored until reset.
  - ERR: lasts one cycle. Sets pkt_error=1 and returns to HUNT. finish stays 0.
- MEM write timing:
  - MEM_write_enable pulses exactly one cycle, registered, in the cycle after the accept edge.
  - MEM_write_addr and MEM_write_data are valid in that same cycle.
  - Payload writes occur only in PAYLOAD.
- Index range: never exceeds len-1 ≤ NUM_DATA-1, so no wrap occurs.
- Sum arithmetic: 8-bit, modulo 256. Sum covers LEN_HI, LEN_LO and payload; the CSUM byte is the two's complement of that sum.
- Bad frames: payload already written stays in MEM (not rolled back). Only finish gates downstream use.
- A SYNC_BYTE value inside LEN or PAYLOAD is data, not a resync.

Optional Feature:
- Macro RX_PARSER_TIMEOUT_EN.
- Defined: a counter clears on every accept and increments while busy. On reaching TIMEOUT_CYCLES it forces ERR (pkt_error=1) and returns to HUNT.
- Undefined: no counter. The parser waits indefinitely between bytes.

Decomposition:
- Shared package uart_pkg holds:
  - state encoding (HUNT, LEN_HI, LEN_LO, PAYLOAD, CSUM, DONE, ERR);
  - SYNC_BYTE default;
  - ADDR_W.
- One sub-module: rx_edge_detect, a registered rising-edge pulse generator for data_ready.

Test Plan:
- Good frame: A5 00 03 11 22 33 97 -> writes addr0=11, addr1=22, addr2=33 (three one-cycle strobes); finish=1, pkt_len=3, pkt_error=0.
- Bad checksum: A5 00 03 11 22 33 98 -> three writes occur; pkt_error=1, finish=0.
  - Then send the good frame -> pkt_error clears at A5; finish=1.
- Leading junk: 00 FF 5A, then the good frame -> junk produces no writes; outcome identical to the good-frame case.
- Length limits:
  - A5 27 11 (length 10001) -> ERR, no writes.
  - A5 40 00 -> ERR.
  - A5 00 00 -> ERR.
  - A5 27 10 + 10000 bytes + correct checksum -> finish=1, last write at addr 9999.
- Level handling and reset:
  - data_ready held high 1000 cycles per byte -> exactly one write per byte.
  - rst=0 after the second payload byte -> all outputs 0, state=HUNT.
  - Then the good frame -> finish=1.
- With RX_PARSER_TIMEOUT_EN: A5 00 03 11, then idle for TIMEOUT_CYCLES -> pkt_error=1, busy=0.
  - Then the good frame -> finish=1.
